computational_unit_pw: RTL

//  Parametrised-width datapath: x0/x1/y0/y1/m/i/o_reg register file, source-selected data_bus, ALU, result r with flags.

---
 rtl/computational_unit_pw.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/computational_unit_pw.sv
// Datapath with a register file, a data_bus source mux, an ALU and a sequential shift-add multiplier.
// Defining CU_SAT_ARITH_EN makes add/sub saturate; r_carry still reports the unsaturated carry or borrow.
module computational_unit_pw #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic              i_sel,
  input  logic              x_sel,
  input  logic              y_sel,
  input  logic [3:0]        source_sel,
  input  logic [3:0]        ir_nibble,
  input  logic [DATA_W-1:0] i_pins,
  input  logic [DATA_W-1:0] dm,
  input  logic [8:0]        reg_en,
  output logic [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] m,
  output logic [DATA_W-1:0] i,
  output logic [DATA_W-1:0] o_reg,
  output logic [DATA_W-1:0] r,
  output logic              r_eq_0,
  output logic              r_neg,
  output logic              r_carry,
  output logic              mul_busy
);

  localparam int PW = 2 * DATA_W;

  typedef enum logic {S_IDLE, S_MUL} state_e;
  typedef enum logic [2:0] {
    F_NEG, F_SUB, F_ADD, F_MULHI, F_MULLO, F_XOR, F_AND, F_NOT
  } alu_fn_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   x0_q, x1_q, y0_q, y1_q, m_q, i_q, o_reg_q, r_q;
  logic                r_eq_0_q, r_neg_q, r_carry_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PW-1:0]       mcand_q, acc_q;
  logic [DATA_W-1:0]   mplier_q;
  logic                hi_sel_q;

  logic [DATA_W-1:0]   pm_data, x_op, y_op, alu_r, mul_res;
  logic [DATA_W:0]     sum, diff;
  logic [PW-1:0]       step_acc;
  logic                op_fire, alu_wr, alu_c, mul_start, mul_done;
  alu_fn_e             func;
  logic                unused_reg_en7;

  assign unused_reg_en7 = reg_en[7];
  assign pm_data = DATA_W'(ir_nibble);
  assign x_op    = x_sel ? x1_q : x0_q;
  assign y_op    = y_sel ? y1_q : y0_q;
  assign sum     = {1'b0, x_op} + {1'b0, y_op};
  assign diff    = {1'b0, x_op} - {1'b0, y_op};
  assign func    = alu_fn_e'(ir_nibble[2:0]);
  // reg_en[4] is only honoured when no multiply is in flight.
  assign op_fire = reg_en[4] && (state_q == S_IDLE);

  always_comb begin
    unique case (source_sel)
      4'd0:    data_bus = x0_q;
      4'd1:    data_bus = x1_q;
      4'd2:    data_bus = y0_q;
      4'd3:    data_bus = y1_q;
      4'd4:    data_bus = r_q;
      4'd5:    data_bus = m_q;
      4'd6:    data_bus = i_q;
      4'd7:    data_bus = dm;
      4'd8:    data_bus = pm_data;
      4'd9:    data_bus = i_pins;
      default: data_bus = '0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    alu_r     = '0;
    alu_c     = 1'b0;
    alu_wr    = 1'b0;
    mul_start = 1'b0;
    if (op_fire) begin
      unique case (func)
        F_NEG: if (!ir_nibble[3]) begin
          alu_wr = 1'b1;
          alu_r  = -x_op;
          alu_c  = |x_op;
        end
        F_SUB: begin
          alu_wr = 1'b1;
          alu_c  = diff[DATA_W];
`ifdef CU_SAT_ARITH_EN
          alu_r  = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
          alu_r  = diff[DATA_W-1:0];
`endif
        end
        F_ADD: begin
          alu_wr = 1'b1;
          alu_c  = sum[DATA_W];
`ifdef CU_SAT_ARITH_EN
          alu_r  = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
          alu_r  = sum[DATA_W-1:0];
`endif
        end
        F_MULHI, F_MULLO: mul_start = 1'b1;
        F_XOR: begin alu_wr = 1'b1; alu_r = x_op ^ y_op; end
        F_AND: begin alu_wr = 1'b1; alu_r = x_op & y_op; end
        F_NOT: if (!ir_nibble[3]) begin
          alu_wr = 1'b1;
          alu_r  = ~x_op;
        end
        default: ;
      endcase
    end
  end

  // The last step's partial sum is folded in combinationally so r lands on the DATA_W-th edge.
  assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_res  = hi_sel_q ? step_acc[PW-1:DATA_W] : step_acc[DATA_W-1:0];
  assign mul_done = (state_q == S_MUL) && (cnt_q == CNT_W'(1));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (sync_reset) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (mul_start) state_d = S_MUL;
      S_MUL:  if (mul_done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mul_busy = (state_q == S_MUL);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      m_q       <= '0;
      i_q       <= '0;
      o_reg_q   <= '0;
      r_q       <= '0;
      r_eq_0_q  <= 1'b1;
      r_neg_q   <= 1'b0;
      r_carry_q <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      hi_sel_q  <= 1'b0;
    end else begin
      if (reg_en[0]) x0_q    <= data_bus;
      if (reg_en[1]) x1_q    <= data_bus;
      if (reg_en[2]) y0_q    <= data_bus;
      if (reg_en[3]) y1_q    <= data_bus;
      if (reg_en[5]) m_q     <= data_bus;
      if (reg_en[6]) i_q     <= i_sel ? i_q + m_q : data_bus;
      if (reg_en[8]) o_reg_q <= data_bus;

      if (mul_start) begin
        mcand_q  <= {{DATA_W{1'b0}}, x_op};
        mplier_q <= y_op;
        acc_q    <= '0;
        cnt_q    <= CNT_W'(DATA_W);
        hi_sel_q <= (func == F_MULHI);
      end else if (state_q == S_MUL) begin
        acc_q    <= step_acc;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CNT_W'(1);
        if (mul_done) begin
          r_q       <= mul_res;
          r_eq_0_q  <= (mul_res == '0);
          r_neg_q   <= mul_res[DATA_W-1];
          r_carry_q <= 1'b0;
        end
      end else if (alu_wr) begin
        r_q       <= alu_r;
        r_eq_0_q  <= (alu_r == '0);
        r_neg_q   <= alu_r[DATA_W-1];
        r_carry_q <= alu_c;
      end
    end
  end

  assign x0      = x0_q;
  assign x1      = x1_q;
  assign y0      = y0_q;
  assign y1      = y1_q;
  assign m       = m_q;
  assign i       = i_q;
  assign o_reg   = o_reg_q;
  assign r       = r_q;
  assign r_eq_0  = r_eq_0_q;
  assign r_neg   = r_neg_q;
  assign r_carry = r_carry_q;

endmodule
